// File: rtl/arith_unit_arbiter_if.sv
// Request/response bundle between the client blocks and arith_unit_arbiter.
// Requester i occupies slice i of each packed request field.
interface arith_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_data_1;
  logic [16*NUM_REQ-1:0] req_data_2;
  logic [2*NUM_REQ-1:0]  req_op_sel;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [15:0]           resp_data;

  modport slave (
    input  req_valid, req_data_1, req_data_2, req_op_sel, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );

  modport master (
    output req_valid, req_data_1, req_data_2, req_op_sel, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/arith_unit_arbiter.sv
// Shares one arithunit among NUM_REQ requesters: round-robin by default,
// fixed lowest-index priority when ARITH_ARB_FIXED_PRIO_EN is defined.
module arith_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  parameter int IDW     = 2
) (
  input  logic                clk,
  input  logic                reset,
  arith_unit_arbiter_if.slave bus,
  output logic [15:0]         alu_data_1,
  output logic [15:0]         alu_data_2,
  output logic [1:0]          alu_op_sel,
  input  logic [15:0]         alu_data_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDW-1:0]     ptr_r;
  logic [IDW-1:0]     ptr_nxt_s;
  logic [IDW-1:0]     win_s;
  logic               any_s;
  logic [2:0]         cnt_r;
  logic               done_s;
  logic [15:0]        op1_s;
  logic [15:0]        op2_s;
  logic [1:0]         op_s;
  logic [IDW-1:0]     resp_id_r;
  logic [15:0]        resp_data_r;
  logic               resp_valid_r;
  logic [NUM_REQ-1:0] ready_s;
  logic [IDW:0]       idx_s;
  logic [IDW:0]       inc_s;

  // Winner search upward from the pointer with wrap; the pointer stays 0 in fixed priority.
  always_comb begin
    win_s = '0;
    any_s = 1'b0;
    idx_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, ptr_r} + (IDW+1)'(k);
      if (idx_s >= (IDW+1)'(NUM_REQ)) begin
        idx_s = idx_s - (IDW+1)'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!any_s && bus.req_valid[idx_s[IDW-1:0]]) begin
        any_s = 1'b1;
        win_s = idx_s[IDW-1:0];
      end else begin
        any_s = any_s;
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    op1_s = 16'd0;
    op2_s = 16'd0;
    op_s  = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_s == IDW'(i)) begin
        op1_s = bus.req_data_1[16*i +: 16];
        op2_s = bus.req_data_2[16*i +: 16];
        op_s  = bus.req_op_sel[2*i +: 2];
      end else begin
        op1_s = op1_s;
      end
    end
  end

  // Pointer value following the owner of the response being retired.
  always_comb begin
    inc_s = {1'b0, resp_id_r} + {{IDW{1'b0}}, 1'b1};
    if (inc_s >= (IDW+1)'(NUM_REQ)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = inc_s[IDW-1:0];
    end
  end

  assign done_s = (state_r == ST_EXEC) && (cnt_r == 3'(ALU_LAT));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = any_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_nxt_s = done_s ? ST_RESP : ST_EXEC;
      ST_RESP: state_nxt_s = bus.resp_ready ? ST_IDLE : ST_RESP;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: one-hot grant only while idle.
  always_comb begin
    busy = (state_r != ST_IDLE);
    if ((state_r == ST_IDLE) && any_s) begin
      ready_s = NUM_REQ'(1) << win_s;
    end else begin
      ready_s = '0;
    end
  end

  // Datapath: operand latch, latency count, result capture and pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_data_1   <= 16'd0;
      alu_data_2   <= 16'd0;
      alu_op_sel   <= 2'd0;
      resp_id_r    <= '0;
      resp_data_r  <= 16'd0;
      resp_valid_r <= 1'b0;
      cnt_r        <= 3'd0;
      ptr_r        <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            alu_data_1 <= op1_s;
            alu_data_2 <= op2_s;
            alu_op_sel <= op_s;
            resp_id_r  <= win_s;
            cnt_r      <= 3'd0;
          end
        end
        ST_EXEC: begin
          cnt_r <= cnt_r + 3'd1;
          if (done_s) begin
            resp_data_r  <= alu_data_out;
            resp_valid_r <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
`ifdef ARITH_ARB_FIXED_PRIO_EN
            ptr_r <= '0;
`else
            ptr_r <= ptr_nxt_s;
`endif
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_data  = resp_data_r;

endmodule

// File: tb/tb_arith_unit_arbiter.sv
// Directed bench for arith_unit_arbiter with a bench-side arithunit model
// (op 0 add, 1 sub, 2 and, 3 xor) at ALU_LAT=1 (dut_a) and ALU_LAT=3 (dut_b).
module tb_arith_unit_arbiter;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  arith_unit_arbiter_if #(.NUM_REQ(4), .IDW(2)) bi1 ();
  arith_unit_arbiter_if #(.NUM_REQ(4), .IDW(2)) bi3 ();

  logic [15:0] a_d1, a_d2, a_out, b_d1, b_d2, b_out, b_p0, b_p1;
  logic [1:0]  a_op, b_op;
  logic        a_busy, b_busy;

  arith_unit_arbiter #(.NUM_REQ(4), .ALU_LAT(1), .IDW(2)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bi1),
    .alu_data_1(a_d1), .alu_data_2(a_d2), .alu_op_sel(a_op),
    .alu_data_out(a_out), .busy(a_busy)
  );

  arith_unit_arbiter #(.NUM_REQ(4), .ALU_LAT(3), .IDW(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bi3),
    .alu_data_1(b_d1), .alu_data_2(b_d2), .alu_op_sel(b_op),
    .alu_data_out(b_out), .busy(b_busy)
  );

  function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x ^ y;
    endcase
  endfunction

  always @(posedge clk) begin
    a_out <= alu_f(a_d1, a_d2, a_op);
    b_p0  <= alu_f(b_d1, b_d2, b_op);
    b_p1  <= b_p0;
    b_out <= b_p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y, input logic [1:0] op);
    bi1.req_data_1[16*i +: 16] = x;
    bi1.req_data_2[16*i +: 16] = y;
    bi1.req_op_sel[2*i +: 2]   = op;
    bi1.req_valid[i]           = 1'b1;
  endtask

  task automatic wait_resp_a();
    int cyc = 0;
    while (!bi1.resp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (bi1.req_ready !== 4'b0000 || bi1.resp_valid !== 1'b0 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b, required 0000/0/0", bi1.req_ready, bi1.resp_valid, a_busy);
    end
    vectors++;
    if (bi1.resp_id !== 2'd0 || bi1.resp_data !== 16'd0 || a_d1 !== 16'd0 || a_d2 !== 16'd0 || a_op !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_data: id=%0d data=%h d1=%h d2=%h op=%0d, required all 0", bi1.resp_id, bi1.resp_data, a_d1, a_d2, a_op);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[5];
    int ng;
    int cyc;
`ifdef ARITH_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0};
    ng = 3;
`else
    exp_g = '{0, 1, 2, 3, 0};
    ng = 5;
`endif
    for (int i = 0; i < 4; i++) set_req(i, 16'(10 * i + 20), 16'(i + 3), 2'(i));
    #1;
    for (int g = 0; g < ng; g++) begin
      cyc = 0;
      while (bi1.req_ready === 4'b0000 && cyc < 20) begin
        tick();
        cyc++;
      end
      vectors++;
      if (bi1.req_ready !== (4'b0001 << exp_g[g])) begin
        miscompares++;
        $display("FAIL rr_grant%0d: ready=%b, required %b", g, bi1.req_ready, 4'b0001 << exp_g[g]);
      end
      tick();
      wait_resp_a();
      vectors++;
      if (bi1.resp_valid !== 1'b1 || bi1.resp_id !== 2'(exp_g[g]) ||
          bi1.resp_data !== alu_f(16'(10 * exp_g[g] + 20), 16'(exp_g[g] + 3), 2'(exp_g[g]))) begin
        miscompares++;
        $display("FAIL rr_resp%0d: valid=%b id=%0d data=%h, required 1/%0d/%h", g, bi1.resp_valid, bi1.resp_id,
                 bi1.resp_data, exp_g[g], alu_f(16'(10 * exp_g[g] + 20), 16'(exp_g[g] + 3), 2'(exp_g[g])));
      end
      if (g == ng - 1) bi1.req_valid = 4'b0000;
      tick();
    end
    tick();
  endtask

  task automatic test_single();
    set_req(2, 16'd3, 16'd4, 2'd0);
    #1;
    vectors++;
    if (bi1.req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_ready: ready=%b, required 0100", bi1.req_ready);
    end
    tick();
    bi1.req_valid[2] = 1'b0;
    vectors++;
    if (a_d1 !== 16'd3 || a_d2 !== 16'd4 || a_op !== 2'd0 || a_busy !== 1'b1 || bi1.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latch: d1=%h d2=%h op=%0d busy=%b valid=%b, required 3/4/0/1/0", a_d1, a_d2, a_op, a_busy, bi1.resp_valid);
    end
    tick();
    vectors++;
    if (bi1.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: resp_valid=%b, required 0", bi1.resp_valid);
    end
    tick();
    vectors++;
    if (bi1.resp_valid !== 1'b1 || bi1.resp_id !== 2'd2 || bi1.resp_data !== 16'd7) begin
      miscompares++;
      $display("FAIL single_resp: valid=%b id=%0d data=%0d, required 1/2/7", bi1.resp_valid, bi1.resp_id, bi1.resp_data);
    end
    tick();
    vectors++;
    if (bi1.resp_valid !== 1'b0 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_onecycle: valid=%b busy=%b, required 0/0", bi1.resp_valid, a_busy);
    end
  endtask

  task automatic test_back_pressure();
    logic bad = 1'b0;
    bi1.resp_ready = 1'b0;
    set_req(0, 16'd100, 16'd23, 2'd1);
    tick();
    bi1.req_valid[0] = 1'b0;
    set_req(1, 16'd50, 16'd5, 2'd0);
    wait_resp_a();
    for (int c = 0; c < 5; c++) begin
      if (bi1.resp_valid !== 1'b1 || bi1.resp_id !== 2'd0 || bi1.resp_data !== 16'd77 || bi1.req_ready !== 4'b0000) bad = 1'b1;
      tick();
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_hold: valid=%b id=%0d data=%0d ready=%b, required 1/0/77/0000 throughout", bi1.resp_valid,
               bi1.resp_id, bi1.resp_data, bi1.req_ready);
    end
    bi1.resp_ready = 1'b1;
    tick();
    vectors++;
    if (bi1.req_ready !== 4'b0010 || bi1.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next_grant: ready=%b valid=%b, required 0010/0", bi1.req_ready, bi1.resp_valid);
    end
    tick();
    bi1.req_valid[1] = 1'b0;
    wait_resp_a();
    vectors++;
    if (bi1.resp_valid !== 1'b1 || bi1.resp_id !== 2'd1 || bi1.resp_data !== 16'd55) begin
      miscompares++;
      $display("FAIL bp_resp2: valid=%b id=%0d data=%0d, required 1/1/55", bi1.resp_valid, bi1.resp_id, bi1.resp_data);
    end
    tick();
  endtask

  task automatic test_ptr_wrap();
    set_req(3, 16'd7, 16'd8, 2'd3);
    #1;
    vectors++;
    if (bi1.req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_first: ready=%b, required 1000", bi1.req_ready);
    end
    tick();
    bi1.req_valid[3] = 1'b0;
    wait_resp_a();
    vectors++;
    if (bi1.resp_id !== 2'd3 || bi1.resp_data !== 16'd15) begin
      miscompares++;
      $display("FAIL wrap_resp1: id=%0d data=%0d, required 3/15", bi1.resp_id, bi1.resp_data);
    end
    set_req(0, 16'd9, 16'd12, 2'd2);
    set_req(3, 16'd1, 16'd2, 2'd0);
    tick();
    vectors++;
    if (bi1.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_second: ready=%b, required 0001", bi1.req_ready);
    end
    tick();
    bi1.req_valid = 4'b0000;
    wait_resp_a();
    vectors++;
    if (bi1.resp_id !== 2'd0 || bi1.resp_data !== 16'd8) begin
      miscompares++;
      $display("FAIL wrap_resp2: id=%0d data=%0d, required 0/8", bi1.resp_id, bi1.resp_data);
    end
    tick();
  endtask

  task automatic test_reset_exec();
    logic seen = 1'b0;
    set_req(1, 16'd1, 16'd1, 2'd0);
    tick();
    bi1.req_valid[1] = 1'b0;
    tick();
    rst_a = 1'b0;
    #1;
    vectors++;
    if (a_busy !== 1'b0 || bi1.req_ready !== 4'b0000 || bi1.resp_valid !== 1'b0 || a_d1 !== 16'd0 || bi1.resp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_exec_now: busy=%b ready=%b valid=%b d1=%h id=%0d, required all 0", a_busy, bi1.req_ready,
               bi1.resp_valid, a_d1, bi1.resp_id);
    end
    tick();
    rst_a = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bi1.resp_valid !== 1'b0 || bi1.req_ready !== 4'b0000 || a_busy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_exec_after: activity seen=%b, required 0", seen);
    end
  endtask

  task automatic test_latency();
    int n = 0;
    bi3.req_data_1[31:16] = 16'd1000;
    bi3.req_data_2[31:16] = 16'd234;
    bi3.req_op_sel[3:2]   = 2'd1;
    bi3.req_valid         = 4'b0010;
    #1;
    vectors++;
    if (bi3.req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL lat_ready: ready=%b, required 0010", bi3.req_ready);
    end
    tick();
    bi3.req_valid = 4'b0000;
    while (!bi3.resp_valid && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL lat_edges: edges=%0d, required 4", n);
    end
    vectors++;
    if (bi3.resp_data !== 16'd766 || bi3.resp_id !== 2'd1) begin
      miscompares++;
      $display("FAIL lat_data: data=%0d id=%0d, required 766/1", bi3.resp_data, bi3.resp_id);
    end
    tick();
    vectors++;
    if (bi3.resp_valid !== 1'b0 || b_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_done: valid=%b busy=%b, required 0/0", bi3.resp_valid, b_busy);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    bi1.req_valid = 4'b0000; bi1.req_data_1 = 64'd0; bi1.req_data_2 = 64'd0; bi1.req_op_sel = 8'd0;
    bi1.resp_ready = 1'b1;
    bi3.req_valid = 4'b0000; bi3.req_data_1 = 64'd0; bi3.req_data_2 = 64'd0; bi3.req_op_sel = 8'd0;
    bi3.resp_ready = 1'b1;
    tick();
    tick();
    test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    test_round_robin();
    test_single();
    test_back_pressure();
    test_ptr_wrap();
    test_reset_exec();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arith_unit_arbiter.md
# arith_unit_arbiter

Round-robin arbiter and sequencer that shares one `arithunit` instance among `NUM_REQ` requesters. Each requester presents two 16-bit operands and a 2-bit `op_sel` on a valid/ready handshake. The arbiter grants one request at a time, drives the shared unit's operand and op inputs, and waits the unit's fixed latency. It then returns the result tagged with the requester index on a valid/ready response channel. It sits between the client blocks and the single `arithunit` in the datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ALU_LAT`, 1: registered latency of `arithunit`, in clocks from stable inputs to valid `data_out`, 1..4.
- `IDW`, 2: width of `resp_id`, equal to `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot grant/accept.
- `req_data_1`  in  16*NUM_REQ  operand 1; requester i occupies bits [16i+15:16i].
- `req_data_2`  in  16*NUM_REQ  operand 2, packed the same way as `req_data_1`.
- `req_op_sel`  in  2*NUM_REQ  op select; requester i occupies bits [2i+1:2i].
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  IDW  index of the requester that owns the result.
- `resp_data`  out  16  result.
- `alu_data_1`, `alu_data_2`  out  16  registered operands to `arithunit`.
- `alu_op_sel`  out  2  registered op select to `arithunit`.
- `alu_data_out`  in  16  `arithunit` result.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, pick the winner (see Configuration). `req_ready[winner]` is driven combinationally in the same cycle. On that edge, latch the operands and op into `alu_*`, latch the winner into `resp_id`, clear the latency counter, and go to EXEC.
  - EXEC: the counter increments each clock. When it reaches `ALU_LAT`, capture `alu_data_out` into `resp_data`, set `resp_valid`, and go to RESP.
  - RESP: hold `resp_valid`, `resp_id` and `resp_data` stable until `resp_valid && resp_ready` at an edge. Then clear `resp_valid`, advance the round-robin pointer to `winner+1` (mod `NUM_REQ`), and go to IDLE.
- `req_ready` is all-zero outside IDLE. At most one bit of `req_ready` is set at any time.
- Requesters must hold `req_valid` and their data stable until accepted; a dropped `req_valid` before acceptance means no request was made.
- `alu_*` hold their last values outside an accept edge.
- Data is passed through unmodified; the arbiter does no arithmetic. Width truncation follows `arithunit`.
- The pointer starts at 0 and wraps from `NUM_REQ-1` to 0.
- Reset values: state IDLE, pointer 0, counter 0, `req_ready` 0, `resp_valid` 0, `resp_id` 0, `resp_data` 0, `alu_*` 0, `busy` 0.
- Reset asserted mid-EXEC or mid-RESP aborts the transaction. No response is produced and the requester is not re-served automatically.
- A requester that re-raises `req_valid` in the same cycle its response is accepted waits for the next IDLE cycle. There is no bypass.

## Timing
- Accept edge E0, where `req_valid[i] && req_ready[i]`. `alu_*` are valid from just after E0.
- `resp_data` is captured at edge E0+`ALU_LAT`+1. `resp_valid` is high from that edge.
- Minimum turnaround is one IDLE cycle after the response handshake. Peak throughput is therefore one result per `ALU_LAT`+3 clocks.
- `resp_ready` held high: `resp_valid` is high for exactly one cycle.
- With `resp_ready` low, back-pressure stalls in RESP indefinitely with no data loss.

## Configuration
- `ARITH_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest asserted `req_valid` index always wins, and the pointer is unused and stays at 0.
  - Undefined (default): round-robin. The first asserted index at or after the pointer, searching upward with wrap, wins.

## Test plan
- Single request: bench `arithunit` model with op 0 = add and `ALU_LAT`=1. Requester 2 sends 3, 4, op 0. Required: `req_ready`=4'b0100 at accept, `resp_valid` two cycles later, `resp_id`=2, `resp_data`=7.
- All four requesters valid continuously, `resp_ready`=1:
  - round-robin build: grants in order 0,1,2,3,0.
  - `ARITH_ARB_FIXED_PRIO_EN` build: grants 0,0,0.
- Back-pressure: `resp_ready`=0 for 5 cycles after `resp_valid`. Required: `resp_data`, `resp_id` and `resp_valid` stable; `req_ready` stays 0 despite a pending request from requester 1; requester 1 is granted in the cycle after the response handshake.
- Pointer wrap: only requester 3 is valid, then requesters 0 and 3 are both valid. Required: the second grant goes to requester 0.
- Reset mid-EXEC: drive `reset` low one cycle after accept. Required: all outputs return to reset values immediately, no `resp_valid`, and `busy`=0.
- Latency parameter: with `ALU_LAT`=3, `resp_valid` rises exactly 4 edges after accept, and `resp_data` equals the model output for the operands used.
